// File: rtl/video_ula_gen.sv
// Palettised video serialiser: byte/pixel timing from CONTROL, 16-entry CW-bit palette,
// hardware cursor inversion, VSYNC-driven auto-flash and auto-incrementing palette port.

module video_ula_pal_entry #(
  parameter int         CW  = 1,
  parameter logic [3:0] IDX = 4'd0
) (
  input  logic          PIXELCLK,
  input  logic          nRESET,
  input  logic          bbc_we,
  input  logic          wide_we,
  input  logic [3:0]    ptr_ent,
  input  logic [1:0]    ptr_ch,
  input  logic [7:0]    pDATA,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          flash
);
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      flash <= 1'b0;
    end else if (bbc_we && pDATA[7:4] == IDX) begin
      // BBC format stores inverted 1-bit guns, widened to the full channel
      flash <= pDATA[3];
      r     <= {CW{~pDATA[0]}};
      g     <= {CW{~pDATA[1]}};
      b     <= {CW{~pDATA[2]}};
    end else if (wide_we && ptr_ent == IDX) begin
      case (ptr_ch)
        2'd1:    g <= pDATA[CW-1:0];
        2'd2:    b <= pDATA[CW-1:0];
        default: r <= pDATA[CW-1:0];
      endcase
    end
  end
endmodule

module video_ula_gen #(
  parameter int CW           = 1,
  parameter int FLASH_FRAMES = 25
) (
  input  logic          PIXELCLK,
  input  logic          nRESET,
  input  logic          PROC_en,
  input  logic          nCS,
  input  logic [1:0]    A,
  input  logic [7:0]    pDATA,
  input  logic [7:0]    vDATA,
  input  logic          DISEN,
  input  logic          CURSOR,
  input  logic          VSYNC,
  output logic          BYTE_en,
  output logic [CW-1:0] RED,
  output logic [CW-1:0] GREEN,
  output logic [CW-1:0] BLUE,
  output logic          FLASH_PHASE
);
  localparam int            FW         = $clog2(FLASH_FRAMES + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

  logic [7:0]           control, shift;
  logic [3:0]           cnt, ptr_ent, pix_idx;
  logic [1:0]           ptr_ch;
  logic [FW-1:0]        fcnt;
  logic                 auto_phase, vsync_q, cur_out;
  logic [2:0]           seg;
  logic [15:0][CW-1:0]  pal_r, pal_g, pal_b;
  logic [15:0]          pal_flash;
  logic                 wr, shift_en, vs_rise;
  logic [CW-1:0]        col_r, col_g, col_b, inv;

  assign wr          = PROC_en & ~nCS;
  assign vs_rise     = VSYNC & ~vsync_q;
  assign BYTE_en     = control[4] ? (cnt[2:0] == 3'd7) : (cnt == 4'd15);
  assign FLASH_PHASE = control[1] ? auto_phase : control[0];
  assign pix_idx     = {shift[7], shift[5], shift[3], shift[1]};

  for (genvar i = 0; i < 16; i++) begin : g_pal
    video_ula_pal_entry #(.CW(CW), .IDX(4'(i))) u_ent (
      .PIXELCLK (PIXELCLK),
      .nRESET   (nRESET),
      .bbc_we   (wr && A == 2'd1),
      .wide_we  (wr && A == 2'd3),
      .ptr_ent  (ptr_ent),
      .ptr_ch   (ptr_ch),
      .pDATA    (pDATA),
      .r        (pal_r[i]),
      .g        (pal_g[i]),
      .b        (pal_b[i]),
      .flash    (pal_flash[i])
    );
  end

  // Pixel rate PR: shift when the low (3-PR) counter bits are all ones
  always_comb begin
    shift_en = 1'b1;
    case (control[3:2])
      2'd0:    shift_en = &cnt[2:0];
      2'd1:    shift_en = &cnt[1:0];
      2'd2:    shift_en = cnt[0];
      default: shift_en = 1'b1;
    endcase
  end

  always_comb begin
    inv   = {CW{pal_flash[pix_idx] & FLASH_PHASE}};
    col_r = DISEN ? (pal_r[pix_idx] ^ inv) : '0;
    col_g = DISEN ? (pal_g[pix_idx] ^ inv) : '0;
    col_b = DISEN ? (pal_b[pix_idx] ^ inv) : '0;
  end

  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      control    <= '0;
      cnt        <= '0;
      shift      <= '0;
      ptr_ent    <= '0;
      ptr_ch     <= '0;
      fcnt       <= '0;
      auto_phase <= 1'b0;
      vsync_q    <= 1'b0;
      seg        <= '0;
      cur_out    <= 1'b0;
      RED        <= '0;
      GREEN      <= '0;
      BLUE       <= '0;
    end else begin
      cnt <= cnt + 4'd1;
      if (wr && A == 2'd0) control <= pDATA;

      if (wr && A == 2'd2) begin
        {ptr_ch, ptr_ent} <= pDATA[5:0];
      end else if (wr && A == 2'd3) begin
        // Channel 3 behaves as R, so it advances to G
        if (ptr_ch == 2'd2) begin
          ptr_ch  <= 2'd0;
          ptr_ent <= ptr_ent + 4'd1;
        end else if (ptr_ch == 2'd1) begin
          ptr_ch <= 2'd2;
        end else begin
          ptr_ch <= 2'd1;
        end
      end

      if (BYTE_en) begin
        shift   <= vDATA;
        seg     <= CURSOR ? 3'b001 : {seg[1:0], 1'b0};
        cur_out <= (CURSOR & control[7]) | (seg[0] & control[6]) |
                   ((seg[1] | seg[2]) & control[5]);
      end else if (shift_en) begin
        shift <= {shift[6:0], 1'b1};
      end

      vsync_q <= VSYNC;
      if (vs_rise) begin
        if (fcnt == FLASH_LAST) begin
          fcnt       <= '0;
          auto_phase <= ~auto_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      {RED, GREEN, BLUE} <= {col_r, col_g, col_b} ^ {(3*CW){cur_out}};
    end
  end
endmodule

// File: tb/tb_video_ula_gen.sv
// Bench for video_ula_gen: vector table, directed corner sequences and a randomized
// run checked against a frame-level reference model.

module tb_video_ula_gen;
  localparam int CW   = 4;
  localparam int FF   = 2;
  localparam int MASK = (1 << CW) - 1;

  logic PIXELCLK = 1'b0, nRESET = 1'b0, PROC_en = 1'b0, nCS = 1'b1;
  logic DISEN = 1'b0, CURSOR = 1'b0, VSYNC = 1'b0;
  logic [1:0] A = '0;
  logic [7:0] pDATA = '0, vDATA = '0;
  logic BYTE_en, FLASH_PHASE;
  logic [CW-1:0] RED, GREEN, BLUE;

  int n_cmp = 0, n_bad = 0;

  video_ula_gen #(.CW(CW), .FLASH_FRAMES(FF)) dut (
    .PIXELCLK(PIXELCLK), .nRESET(nRESET), .PROC_en(PROC_en), .nCS(nCS), .A(A),
    .pDATA(pDATA), .vDATA(vDATA), .DISEN(DISEN), .CURSOR(CURSOR), .VSYNC(VSYNC),
    .BYTE_en(BYTE_en), .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .FLASH_PHASE(FLASH_PHASE)
  );

  always #31 PIXELCLK = ~PIXELCLK;

  // Reference model: time is counted in edges since reset release; the shift state is
  // derived from the last loaded byte and the pixel period, the cursor from load distances.
  int       m_e, m_pe, m_pc, m_last_load, m_nload, m_last_cur, m_rises;
  bit [7:0] m_ctrl, m_byte;
  int       m_r[16], m_g[16], m_b[16];
  bit       m_fl[16];
  bit       m_valid, m_cur, m_vsp, exp_ben, exp_chk;
  int       exp_rgb;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
    end
  endtask

  function automatic bit m_fphase();
    return m_ctrl[1] ? ((m_rises / FF) % 2 == 1) : m_ctrl[0];
  endfunction

  task automatic model_reset();
    m_e = 0; m_pe = 0; m_pc = 0; m_last_load = 0; m_nload = 0; m_last_cur = -100;
    m_rises = 0; m_ctrl = '0; m_byte = '0; m_valid = 0; m_cur = 0; m_vsp = 0;
    for (int i = 0; i < 16; i++) begin
      m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_fl[i] = 0;
    end
  endtask

  task automatic model_pre();
    int c, pp, k, s, r, g, b, idx;
    bit [7:0] sb;
    c = m_e % 16;
    exp_ben = m_ctrl[4] ? (c % 8 == 7) : (c == 15);
    pp = 1 << (3 - int'(m_ctrl[3:2]));
    k = (m_e - m_last_load) / pp;
    if (k > 8) k = 8;
    s = ((int'(m_byte) << k) | ((1 << k) - 1)) & 255;
    sb = s[7:0];
    idx = {sb[7], sb[5], sb[3], sb[1]};
    r = m_r[idx]; g = m_g[idx]; b = m_b[idx];
    if (m_fl[idx] && m_fphase()) begin
      r ^= MASK; g ^= MASK; b ^= MASK;
    end
    if (!DISEN) begin
      r = 0; g = 0; b = 0;
    end
    if (m_cur) begin
      r ^= MASK; g ^= MASK; b ^= MASK;
    end
    exp_rgb = (r << (2 * CW)) | (g << CW) | b;
    exp_chk = m_valid;
  endtask

  task automatic model_post();
    int d, ent, ch;
    m_e++;
    if (exp_ben) begin
      d = m_nload - m_last_cur;
      m_cur = (CURSOR && m_ctrl[7]) || (d == 1 && m_ctrl[6]) ||
              ((d == 2 || d == 3) && m_ctrl[5]);
      if (CURSOR) m_last_cur = m_nload;
      m_nload++;
      m_byte = vDATA; m_last_load = m_e; m_valid = 1;
    end
    if (VSYNC && !m_vsp) m_rises++;
    m_vsp = VSYNC;
    if (PROC_en && !nCS) begin
      case (A)
        2'd0: begin m_ctrl = pDATA; m_valid = 0; end
        2'd1: begin
          ent = int'(pDATA[7:4]);
          m_fl[ent] = pDATA[3];
          m_b[ent] = pDATA[2] ? 0 : MASK;
          m_g[ent] = pDATA[1] ? 0 : MASK;
          m_r[ent] = pDATA[0] ? 0 : MASK;
        end
        2'd2: begin m_pc = int'(pDATA[5:4]); m_pe = int'(pDATA[3:0]); end
        default: begin
          ch = (m_pc == 3) ? 0 : m_pc;
          if (ch == 0) m_r[m_pe] = pDATA & MASK;
          else if (ch == 1) m_g[m_pe] = pDATA & MASK;
          else m_b[m_pe] = pDATA & MASK;
          if (ch == 2) begin m_pc = 0; m_pe = (m_pe + 1) % 16; end
          else m_pc = ch + 1;
        end
      endcase
    end
  endtask

  // One PIXELCLK edge: inputs are already set in the low phase
  task automatic clk_step();
    if (!nRESET) begin
      @(posedge PIXELCLK); #1;
      model_reset();
      check("rst_rgb", {RED, GREEN, BLUE}, 0);
      check("rst_byte_en", BYTE_en, 0);
      check("rst_flash", FLASH_PHASE, 0);
    end else begin
      model_pre();
      check("byte_en", BYTE_en, exp_ben);
      model_post();
      @(posedge PIXELCLK); #1;
      if (exp_chk) check("rgb", {RED, GREEN, BLUE}, exp_rgb);
      check("flash_phase", FLASH_PHASE, m_fphase());
    end
    @(negedge PIXELCLK);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    PROC_en = 1'b1; nCS = 1'b0; A = a; pDATA = d;
    clk_step();
    PROC_en = 1'b0; nCS = 1'b1;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    clk_step();
    clk_step();
    nRESET = 1'b1;
  endtask

  task automatic wait_byte_en(input string name);
    int n;
    n = 0;
    while (!BYTE_en && n < 40) begin clk_step(); n++; end
    check(name, BYTE_en, 1);
  endtask

  // Load a byte, then return with RGB showing its first pixel
  task automatic show(input logic [7:0] byt, input string name, input int exp);
    vDATA = byt;
    wait_byte_en("load_timeout");
    clk_step();
    clk_step();
    check(name, {RED, GREEN, BLUE}, exp);
  endtask

  typedef struct {
    logic [7:0]  pal;
    logic [7:0]  vbyte;
    logic        disen;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n;
    bit ph_exp[4];
    bit [7:0] ctrl;

    tbl[0] = '{8'h07, 8'h00, 1'b1, 12'h000};
    tbl[1] = '{8'hF0, 8'hAA, 1'b1, 12'hFFF};
    tbl[2] = '{8'h56, 8'h22, 1'b1, 12'hF00};
    tbl[3] = '{8'h3D, 8'h0A, 1'b1, 12'h0F0};
    tbl[4] = '{8'hA3, 8'h88, 1'b1, 12'h00F};
    tbl[5] = '{8'h60, 8'h28, 1'b0, 12'h000};
    ph_exp[0] = 0; ph_exp[1] = 1; ph_exp[2] = 1; ph_exp[3] = 0;
    model_reset();

    // First load after reset, then fast rate with PR=3 alternating pixels
    do_reset();
    n = 0;
    while (!BYTE_en && n < 40) begin clk_step(); n++; end
    check("first_load_edge", n + 1, 16);
    cpu_wr(2'd1, 8'hF0);
    cpu_wr(2'd1, 8'h07);
    cpu_wr(2'd0, 8'h1C);
    vDATA = 8'hAA; DISEN = 1'b1;
    wait_byte_en("load_timeout");
    clk_step();
    for (int i = 0; i < 8; i++) begin
      clk_step();
      check("alt_pixel", {RED, GREEN, BLUE}, (i % 2 == 0) ? 12'hFFF : 12'h000);
    end
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (BYTE_en) n++;
      clk_step();
    end
    check("fast_rate_loads", n, 8);

    // BBC-format palette vectors, one constant pixel per byte
    cpu_wr(2'd0, 8'h10);
    for (int i = 0; i < 6; i++) begin
      cpu_wr(2'd1, tbl[i].pal);
      DISEN = tbl[i].disen;
      show(tbl[i].vbyte, $sformatf("tbl_%0d", i), int'(tbl[i].rgb));
    end

    // Wide palette port with auto-increment and wrap
    do_reset();
    cpu_wr(2'd0, 8'h10);
    DISEN = 1'b1;
    cpu_wr(2'd2, 8'h05);
    cpu_wr(2'd3, 8'h03); cpu_wr(2'd3, 8'h09); cpu_wr(2'd3, 8'h0C); cpu_wr(2'd3, 8'h01);
    show(8'h22, "wide_entry5", 12'h39C);
    show(8'h28, "wide_entry6_r", 12'h100);
    cpu_wr(2'd3, 8'h07);
    show(8'h28, "wide_entry6_g", 12'h170);
    cpu_wr(2'd2, 8'h2F);
    cpu_wr(2'd3, 8'h05);
    cpu_wr(2'd3, 8'h0A);
    show(8'hAA, "wrap_entry15_b", 12'h005);
    show(8'h00, "wrap_entry0_r", 12'hA00);

    // Auto-flash every FF VSYNC rising edges
    do_reset();
    cpu_wr(2'd1, 8'h3D);
    cpu_wr(2'd0, 8'h12);
    DISEN = 1'b1;
    show(8'h0A, "flash_base", 12'h0F0);
    for (int p = 0; p < 4; p++) begin
      VSYNC = 1'b1;
      repeat (3) clk_step();
      VSYNC = 1'b0;
      repeat (3) clk_step();
      check($sformatf("flash_phase_p%0d", p + 1), FLASH_PHASE, ph_exp[p]);
      check($sformatf("flash_rgb_p%0d", p + 1), {RED, GREEN, BLUE},
            ph_exp[p] ? 12'hF0F : 12'h0F0);
    end

    // Cursor: four inverted bytes, display disabled
    do_reset();
    DISEN = 1'b0; vDATA = 8'h00;
    cpu_wr(2'd0, 8'hE0);
    wait_byte_en("cursor_wait");
    CURSOR = 1'b1;
    clk_step();
    CURSOR = 1'b0;
    n = 0;
    for (int i = 0; i < 96; i++) begin
      clk_step();
      if ({RED, GREEN, BLUE} == 12'hFFF) n++;
    end
    check("cursor_cycles", n, 64);

    // Reset mid-line clears palette and restarts timing
    cpu_wr(2'd1, 8'h00);
    cpu_wr(2'd0, 8'h10);
    DISEN = 1'b1;
    show(8'h00, "pre_reset_rgb", 12'hFFF);
    repeat (3) clk_step();
    nRESET = 1'b0;
    clk_step();
    nRESET = 1'b1;
    n = 0;
    while (!BYTE_en && n < 40) begin clk_step(); n++; end
    check("restart_load_edge", n + 1, 16);
    clk_step();
    clk_step();
    check("pal_cleared", {RED, GREEN, BLUE}, 0);

    // Randomized traffic against the model
    for (int run = 0; run < 4; run++) begin
      do_reset();
      ctrl = 8'($urandom);
      cpu_wr(2'd0, ctrl);
      for (int i = 0; i < 1500; i++) begin
        vDATA  = 8'($urandom);
        DISEN  = ($urandom_range(0, 3) != 0);
        CURSOR = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 40) == 0) VSYNC = ~VSYNC;
        if ($urandom_range(0, 7) == 0) begin
          PROC_en = 1'b1;
          nCS = ($urandom_range(0, 3) == 0);
          A = 2'($urandom_range(1, 3));
          pDATA = 8'($urandom);
        end else begin
          PROC_en = 1'($urandom_range(0, 1));
          nCS = 1'b1;
        end
        clk_step();
      end
      PROC_en = 1'b0; nCS = 1'b1; CURSOR = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
